// File: rtl/smi_frame_steer_x4.sv
// Steers whole SMI frames from one input to four outputs, selected by the header flit's route field.
// Optional: define SMI_FRAME_STEER_DROP_EN to widen the route to Data[2:0] and discard frames routed to 4-7.
module smi_frame_steer_x4 #(
  parameter int unsigned FlitWidth = 2,
  parameter int unsigned EofcMask  = 2*FlitWidth-1
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   smiInReady,
  input  logic [7:0]             smiInEofc,
  input  logic [FlitWidth*8-1:0] smiInData,
  output logic                   smiInStop,
  output logic                   smiOutAReady,
  output logic [7:0]             smiOutAEofc,
  output logic [FlitWidth*8-1:0] smiOutAData,
  input  logic                   smiOutAStop,
  output logic                   smiOutBReady,
  output logic [7:0]             smiOutBEofc,
  output logic [FlitWidth*8-1:0] smiOutBData,
  input  logic                   smiOutBStop,
  output logic                   smiOutCReady,
  output logic [7:0]             smiOutCEofc,
  output logic [FlitWidth*8-1:0] smiOutCData,
  input  logic                   smiOutCStop,
  output logic                   smiOutDReady,
  output logic [7:0]             smiOutDEofc,
  output logic [FlitWidth*8-1:0] smiOutDData,
  input  logic                   smiOutDStop
);

  localparam int unsigned DataW        = FlitWidth*8;
  localparam logic [7:0]  EofcMaskBits = EofcMask[7:0];

  typedef enum logic [2:0] {
    Header,
    FwdA,
    FwdB,
    FwdC,
    FwdD
`ifdef SMI_FRAME_STEER_DROP_EN
    , Drop
`endif
  } stateT;

  stateT state, stateNext;

  logic             inReady_q;
  logic             inLast_q;
  logic [7:0]       inEofc_q;
  logic [DataW-1:0] inData_q;
  logic             inHalt;
  logic             inLoad;
  logic             xfer;

  logic [1:0]       tgt;
  logic             tgtValid;
  logic [3:0]       tgtOneHot;

  logic [3:0]       outReady;
  logic [3:0]       outStop;
  logic [3:0]       outLoad;
  logic [7:0]       outEofc [4];
  logic [DataW-1:0] outData [4];

`ifdef SMI_FRAME_STEER_DROP_EN
  logic [2:0] route;
  assign route = inData_q[2:0];
`else
  logic [1:0] route;
  assign route = inData_q[1:0];
`endif

  // Input skid-free stage: holds its flit only while the steered output refuses it.
  assign inLoad    = ~(inReady_q & inHalt);
  assign smiInStop = inReady_q & inHalt;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      inReady_q <= 1'b0;
    end else if (inLoad) begin
      inReady_q <= smiInReady;
    end
  end

  always_ff @(posedge clk) begin
    if (inLoad) begin
      inEofc_q <= smiInEofc & EofcMaskBits;
      inData_q <= smiInData;
      inLast_q <= |smiInEofc;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= Header;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    tgtValid  = 1'b1;
    tgt       = route[1:0];
    case (state)
      Header: begin
`ifdef SMI_FRAME_STEER_DROP_EN
        tgtValid = ~route[2];
`endif
      end
      FwdA:    tgt = 2'd0;
      FwdB:    tgt = 2'd1;
      FwdC:    tgt = 2'd2;
      FwdD:    tgt = 2'd3;
      default: tgtValid = 1'b0;
    endcase

    tgtOneHot = tgtValid ? (4'b0001 << tgt) : 4'b0000;
    inHalt    = |(tgtOneHot & outReady & outStop);
    xfer      = inReady_q & ~inHalt;

    // A single-flit frame (Last on the header) never leaves Header.
    if (xfer) begin
      if (state == Header) begin
        if (!inLast_q) begin
          unique case (tgt)
            2'd0: stateNext = FwdA;
            2'd1: stateNext = FwdB;
            2'd2: stateNext = FwdC;
            2'd3: stateNext = FwdD;
          endcase
`ifdef SMI_FRAME_STEER_DROP_EN
          if (!tgtValid) begin
            stateNext = Drop;
          end
`endif
        end
      end else if (inLast_q) begin
        stateNext = Header;
      end
    end
  end

  // Each output register refills every cycle it is not holding a stopped flit; untargeted ones load idle.
  assign outStop = {smiOutDStop, smiOutCStop, smiOutBStop, smiOutAStop};
  assign outLoad = ~(outReady & outStop);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      outReady <= 4'b0000;
    end else begin
      outReady <= (outReady & ~outLoad) | (outLoad & {4{inReady_q}} & tgtOneHot);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (outLoad[i]) begin
        outEofc[i] <= inEofc_q;
        outData[i] <= inData_q;
      end
    end
  end

  assign smiOutAReady = outReady[0];
  assign smiOutAEofc  = outEofc[0];
  assign smiOutAData  = outData[0];
  assign smiOutBReady = outReady[1];
  assign smiOutBEofc  = outEofc[1];
  assign smiOutBData  = outData[1];
  assign smiOutCReady = outReady[2];
  assign smiOutCEofc  = outEofc[2];
  assign smiOutCData  = outData[2];
  assign smiOutDReady = outReady[3];
  assign smiOutDEofc  = outEofc[3];
  assign smiOutDData  = outData[3];

endmodule

// File: tb/tb_smi_frame_steer_x4.sv
// Directed self-checking bench for smi_frame_steer_x4 (default FlitWidth=2, Eofc mask 3).
module tb_smi_frame_steer_x4;

  logic        clk;
  logic        arst_n;
  logic        smiInReady;
  logic [7:0]  smiInEofc;
  logic [15:0] smiInData;
  logic        smiInStop;
  logic        smiOutAReady, smiOutBReady, smiOutCReady, smiOutDReady;
  logic [7:0]  smiOutAEofc, smiOutBEofc, smiOutCEofc, smiOutDEofc;
  logic [15:0] smiOutAData, smiOutBData, smiOutCData, smiOutDData;
  logic        smiOutAStop, smiOutBStop, smiOutCStop, smiOutDStop;

  int assertCount = 0;
  int failCount   = 0;

  logic [3:0]  outRdy;
  logic [15:0] outDat  [4];
  logic [7:0]  outEofc [4];

  assign outRdy     = {smiOutDReady, smiOutCReady, smiOutBReady, smiOutAReady};
  assign outDat[0]  = smiOutAData;
  assign outDat[1]  = smiOutBData;
  assign outDat[2]  = smiOutCData;
  assign outDat[3]  = smiOutDData;
  assign outEofc[0] = smiOutAEofc;
  assign outEofc[1] = smiOutBEofc;
  assign outEofc[2] = smiOutCEofc;
  assign outEofc[3] = smiOutDEofc;

  smi_frame_steer_x4 dut (
    .clk(clk), .arst_n(arst_n),
    .smiInReady(smiInReady), .smiInEofc(smiInEofc), .smiInData(smiInData), .smiInStop(smiInStop),
    .smiOutAReady(smiOutAReady), .smiOutAEofc(smiOutAEofc), .smiOutAData(smiOutAData), .smiOutAStop(smiOutAStop),
    .smiOutBReady(smiOutBReady), .smiOutBEofc(smiOutBEofc), .smiOutBData(smiOutBData), .smiOutBStop(smiOutBStop),
    .smiOutCReady(smiOutCReady), .smiOutCEofc(smiOutCEofc), .smiOutCData(smiOutCData), .smiOutCStop(smiOutCStop),
    .smiOutDReady(smiOutDReady), .smiOutDEofc(smiOutDEofc), .smiOutDData(smiOutDData), .smiOutDStop(smiOutDStop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    arst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      assertCount++;
      if (outRdy[p] !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL reset ready port=%0d got %b want 0", p, outRdy[p]);
      end
    end
    assertCount++;
    if (smiInStop !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset inStop got %b want 0", smiInStop);
    end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 3-flit frame to C; the second flit's route bits point at B but must follow the frame.
  task automatic test_route_c();
    logic [15:0] vd [3] = '{16'h0102, 16'hAA11, 16'hBB22};
    logic [7:0]  ve [3] = '{8'h00, 8'h00, 8'h01};
    int          vp [3] = '{2, 2, 2};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 3) begin
        smiInReady = 1'b1; smiInEofc = ve[c]; smiInData = vd[c];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        int k;
        logic expRdy;
        k = c - 2;
        expRdy = (k >= 0 && k < 3) ? (vp[k] == p) : 1'b0;
        assertCount++;
        if (outRdy[p] !== expRdy) begin
          failCount++;
          $display("[TB] FAIL routeC ready c=%0d port=%0d got %b want %b", c, p, outRdy[p], expRdy);
        end else if (expRdy) begin
          assertCount++;
          if (outDat[p] !== vd[k] || outEofc[p] !== (ve[k] & 8'h03)) begin
            failCount++;
            $display("[TB] FAIL routeC flit c=%0d got %h/%h want %h/%h", c, outDat[p], outEofc[p], vd[k], ve[k] & 8'h03);
          end
        end
      end
      assertCount++;
      if (smiInStop !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL routeC inStop c=%0d got %b want 0", c, smiInStop);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vd [5] = '{16'h1000, 16'h1111, 16'h2003, 16'h2222, 16'h2333};
    logic [7:0]  ve [5] = '{8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
    int          vp [5] = '{0, 0, 3, 3, 3};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 5) begin
        smiInReady = 1'b1; smiInEofc = ve[c]; smiInData = vd[c];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        int k;
        logic expRdy;
        k = c - 2;
        expRdy = (k >= 0 && k < 5) ? (vp[k] == p) : 1'b0;
        assertCount++;
        if (outRdy[p] !== expRdy) begin
          failCount++;
          $display("[TB] FAIL backToBack ready c=%0d port=%0d got %b want %b", c, p, outRdy[p], expRdy);
        end else if (expRdy) begin
          assertCount++;
          if (outDat[p] !== vd[k] || outEofc[p] !== (ve[k] & 8'h03)) begin
            failCount++;
            $display("[TB] FAIL backToBack flit c=%0d got %h/%h want %h/%h", c, outDat[p], outEofc[p], vd[k], ve[k] & 8'h03);
          end
        end
      end
      assertCount++;
      if (smiInStop !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL backToBack inStop c=%0d got %b want 0", c, smiInStop);
      end
    end
  endtask

  // Single-flit frames with Eofc=2 to A,B,C,D in consecutive cycles.
  task automatic test_single_flit();
    logic [15:0] vd [4] = '{16'h3000, 16'h3101, 16'h3202, 16'h3303};
    int          vp [4] = '{0, 1, 2, 3};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 4) begin
        smiInReady = 1'b1; smiInEofc = 8'h02; smiInData = vd[c];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        int k;
        logic expRdy;
        k = c - 2;
        expRdy = (k >= 0 && k < 4) ? (vp[k] == p) : 1'b0;
        assertCount++;
        if (outRdy[p] !== expRdy) begin
          failCount++;
          $display("[TB] FAIL singleFlit ready c=%0d port=%0d got %b want %b", c, p, outRdy[p], expRdy);
        end else if (expRdy) begin
          assertCount++;
          if (outDat[p] !== vd[k] || outEofc[p] !== 8'h02) begin
            failCount++;
            $display("[TB] FAIL singleFlit flit c=%0d got %h/%h want %h/02", c, outDat[p], outEofc[p], vd[k]);
          end
        end
      end
    end
  endtask

  // B stopped for 5 cycles mid-frame while A is also stopped; every flit must arrive once, in order.
  task automatic test_stop();
    logic [15:0] vd [5] = '{16'h4001, 16'h4111, 16'h4222, 16'h4333, 16'h4444};
    logic [7:0]  ve [5] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    int   idx = 0;
    int   rx = 0;
    logic pend = 1'b0;
    logic sawStop = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (pend) idx++;
      if (idx < 5) begin
        smiInReady = 1'b1; smiInEofc = ve[idx]; smiInData = vd[idx];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      smiOutBStop = (c >= 4 && c < 9);
      smiOutAStop = (c >= 2 && c < 12);
      #1;
      if (smiOutBReady && !smiOutBStop) begin
        assertCount++;
        if (rx >= 5) begin
          failCount++;
          $display("[TB] FAIL stopB extra flit got %h want none", smiOutBData);
        end else if (smiOutBData !== vd[rx] || smiOutBEofc !== (ve[rx] & 8'h03)) begin
          failCount++;
          $display("[TB] FAIL stopB flit %0d got %h/%h want %h/%h", rx, smiOutBData, smiOutBEofc, vd[rx], ve[rx] & 8'h03);
        end
        rx++;
      end
      assertCount++;
      if ({smiOutAReady, smiOutCReady, smiOutDReady} !== 3'b000) begin
        failCount++;
        $display("[TB] FAIL stopB otherReady c=%0d got %b want 000", c, {smiOutAReady, smiOutCReady, smiOutDReady});
      end
      pend = smiInReady && !smiInStop;
      if (smiInStop) sawStop = 1'b1;
    end
    smiOutAStop = 1'b0;
    smiOutBStop = 1'b0;
    assertCount++;
    if (rx != 5) begin
      failCount++;
      $display("[TB] FAIL stopB count got %0d want 5", rx);
    end
    assertCount++;
    if (sawStop !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL stopB inStop seen got %b want 1", sawStop);
    end
  endtask

  // Reset while the 2nd flit of an A-frame sits in the input register; next frame goes to B.
  task automatic test_reset_mid();
    logic [15:0] vd [2] = '{16'h6001, 16'h6111};
    logic [7:0]  ve [2] = '{8'h00, 8'h01};
    @(negedge clk);
    smiInReady = 1'b1; smiInEofc = 8'h00; smiInData = 16'h5000;
    @(negedge clk);
    smiInData = 16'h5111;
    @(negedge clk);
    smiInReady = 1'b0; smiInData = 16'h0000;
    #1;
    assertCount++;
    if (smiOutAReady !== 1'b1 || smiOutAData !== 16'h5000) begin
      failCount++;
      $display("[TB] FAIL resetMid preA got %b/%h want 1/5000", smiOutAReady, smiOutAData);
    end
    arst_n = 1'b0;
    #1;
    assertCount++;
    if (outRdy !== 4'b0000 || smiInStop !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL resetMid clear got %b/%b want 0000/0", outRdy, smiInStop);
    end
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c < 2) begin
        smiInReady = 1'b1; smiInEofc = ve[c]; smiInData = vd[c];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        int k;
        logic expRdy;
        k = c - 2;
        expRdy = (k >= 0 && k < 2) ? (p == 1) : 1'b0;
        assertCount++;
        if (outRdy[p] !== expRdy) begin
          failCount++;
          $display("[TB] FAIL resetMid ready c=%0d port=%0d got %b want %b", c, p, outRdy[p], expRdy);
        end else if (expRdy) begin
          assertCount++;
          if (outDat[p] !== vd[k] || outEofc[p] !== ve[k]) begin
            failCount++;
            $display("[TB] FAIL resetMid flit c=%0d got %h/%h want %h/%h", c, outDat[p], outEofc[p], vd[k], ve[k]);
          end
        end
      end
    end
  endtask

  // Route 5 frame: discarded when the drop option is built in, otherwise lands on B (route bits 01).
  task automatic test_drop();
    logic [15:0] vd [5] = '{16'h7005, 16'h7111, 16'h7222, 16'h8000, 16'h8111};
    logic [7:0]  ve [5] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h01};
`ifdef SMI_FRAME_STEER_DROP_EN
    int          vp [5] = '{4, 4, 4, 0, 0};
`else
    int          vp [5] = '{1, 1, 1, 0, 0};
`endif
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c < 5) begin
        smiInReady = 1'b1; smiInEofc = ve[c]; smiInData = vd[c];
      end else begin
        smiInReady = 1'b0; smiInEofc = 8'h00; smiInData = 16'h0000;
      end
      #1;
      for (int p = 0; p < 4; p++) begin
        int k;
        logic expRdy;
        k = c - 2;
        expRdy = (k >= 0 && k < 5) ? (vp[k] == p) : 1'b0;
        assertCount++;
        if (outRdy[p] !== expRdy) begin
          failCount++;
          $display("[TB] FAIL drop ready c=%0d port=%0d got %b want %b", c, p, outRdy[p], expRdy);
        end else if (expRdy) begin
          assertCount++;
          if (outDat[p] !== vd[k] || outEofc[p] !== ve[k]) begin
            failCount++;
            $display("[TB] FAIL drop flit c=%0d got %h/%h want %h/%h", c, outDat[p], outEofc[p], vd[k], ve[k]);
          end
        end
      end
      assertCount++;
      if (smiInStop !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL drop inStop c=%0d got %b want 0", c, smiInStop);
      end
    end
  endtask

  initial begin
    smiInReady  = 1'b0;
    smiInEofc   = 8'h00;
    smiInData   = 16'h0000;
    smiOutAStop = 1'b0;
    smiOutBStop = 1'b0;
    smiOutCStop = 1'b0;
    smiOutDStop = 1'b0;
    arst_n      = 1'b0;
    test_reset();
    test_route_c();
    test_back_to_back();
    test_single_flit();
    test_stop();
    test_reset_mid();
    test_drop();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
